// File: rtl/tt_um_suba_spi.sv
// ---------------------------------------------------------------------------
// tt_um_suba_spi
//
// SPI slave (mode 0, MSB first, 8-bit frames) inside the Tiny Tapeout
// user-module wrapper. The SPI pins are oversampled by the system clock:
// SCLK is never used as a clock, only as a synchronized data signal whose
// edges are detected in the clk domain. Each completed byte is presented on
// uo_out. MISO echoes the previously received byte, so an external master
// can run a loopback check.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   ena      harness design-enable (unused)
//   ui_in    [0] SCLK, [1] CS_N (active low), [2] MOSI, [7:3] unused
//   uo_out   last completely received byte
//   uio_in   unused
//   uio_out  [0] MISO, [1] byte_done pulse, [2] busy, [7:3] zero
//   uio_oe   constant 8'h07 (low three bidirectional pins are outputs)
// ---------------------------------------------------------------------------
module tt_um_suba_spi (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Synchronizer chains. Stages _p0/_p1 form the 2-FF synchronizer; the
    // _p2 stage of SCLK and CS_N holds the previous synchronized sample for
    // edge detection. MOSI only needs _p1, which lines up with the SCLK
    // sample that reveals a rising edge.
    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_n_p0, cs_n_p1, cs_n_p2;
    logic mosi_p0, mosi_p1;

    // Receive / transmit state
    logic [7:0] rx_shift;
    logic [7:0] rx_data;
    logic [7:0] tx_shift;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic       busy;
    // Set on the 8th SCLK rise; tells the following SCLK fall to reload
    // tx_shift from the freshly completed byte instead of shifting.
    logic       byte_full;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_active;
    logic cs_fall;
    logic miso;
    logic [7:0] rx_next;

    // Harness inputs that this design does not use.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

    // ---- stage p0..p2: pin synchronizers ----------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_n_p0 <= 1'b1;
            cs_n_p1 <= 1'b1;
            cs_n_p2 <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= ui_in[0];
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_n_p0 <= ui_in[1];
            cs_n_p1 <= cs_n_p0;
            cs_n_p2 <= cs_n_p1;
            mosi_p0 <= ui_in[2];
            mosi_p1 <= mosi_p0;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_active = ~cs_n_p1;
    assign cs_fall   = ~cs_n_p1 & cs_n_p2;
    assign rx_next   = {rx_shift[6:0], mosi_p1};

    // ---- frame control and receive path -----------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift  <= 8'h00;
            rx_data   <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            byte_full <= 1'b0;
            busy      <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cs_fall) begin
                // New frame: start counting from bit 7 again.
                rx_shift  <= 8'h00;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                busy      <= 1'b1;
            end else if (!cs_active) begin
                // CS idle (or just released mid-byte): any partial byte is
                // dropped and rx_data keeps the last complete one.
                rx_shift  <= 8'h00;
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                busy      <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data   <= rx_next;
                        byte_done <= 1'b1;
                        byte_full <= 1'b1;
                    end
                end else if (sclk_fall && byte_full) begin
                    byte_full <= 1'b0;
                end
            end
        end
    end

    // ---- transmit path ------------------------------------------------------
    // tx_shift is preloaded with rx_data at frame start so the first MISO
    // bit is ready before the first SCLK rise; later bits move on SCLK falls.
    // At a byte boundary inside one CS frame the fall after the 8th rise
    // reloads the new rx_data, so back-to-back bytes keep echoing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= 8'h00;
        end else if (cs_fall) begin
            tx_shift <= rx_data;
        end else if (cs_active && sclk_fall) begin
            if (byte_full) begin
                tx_shift <= rx_data;
            end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    // busy and tx_shift are both registers, so MISO changes on the clk edge
    // that ends the detect cycle, and is forced low while CS is inactive.
    assign miso    = busy & tx_shift[7];

    assign uo_out  = rx_data;
    assign uio_out = {5'b00000, busy, byte_done, miso};
    assign uio_oe  = 8'h07;

endmodule

// File: tb/tb_tt_um_suba_spi.sv
module tb_tt_um_suba_spi;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic sclk;
    logic cs_n;
    logic mosi;

    assign ui_in  = {5'b00000, mosi, cs_n, sclk};
    assign uio_in = 8'h00;

    tt_um_suba_spi dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic prev_done = 1'b0;

    // Scoreboard: bytes that the master completed, in order.
    logic [7:0] exp_q[$];
    // Reference model: last byte the slave fully received (what it echoes).
    logic [7:0] model_prev = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every byte_done pulse must match the next queued byte and
    // must last a single clk.
    always @(negedge clk) begin
        if (uio_out[1] === 1'b1) begin
            pulses++;
            check("byte_done single-cycle", {31'b0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected byte_done: got uo_out 0x%0h, no byte expected", uo_out);
            end else begin
                check("rx byte", {24'b0, uo_out}, {24'b0, exp_q.pop_front()});
            end
        end
        prev_done = uio_out[1];
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SCLK = clk/8: MOSI set 2 clk before the rise, high 4 clk, low 4 clk.
    // MISO is sampled at the moment SCLK is driven high.
    task automatic shift_bits(input logic [7:0] b, input int n, output logic [7:0] echo);
        echo = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            tick(2);
            sclk = 1'b1;
            echo = {echo[6:0], uio_out[0]};
            tick(4);
            sclk = 1'b0;
            tick(2);
        end
    endtask

    task automatic begin_frame();
        cs_n = 1'b0;
        tick(4);
        check("busy during frame", {31'b0, uio_out[2]}, 32'd1);
    endtask

    task automatic end_frame();
        tick(2);
        cs_n = 1'b1;
        tick(6);
        check("busy after frame", {31'b0, uio_out[2]}, 32'd0);
    endtask

    // One byte inside an already open frame; expectation queued first.
    task automatic frame_byte(input logic [7:0] b);
        logic [7:0] echo;
        logic [7:0] exp_echo;
        exp_echo = model_prev;
        exp_q.push_back(b);
        model_prev = b;
        shift_bits(b, 8, echo);
        check("miso echo", {24'b0, echo}, {24'b0, exp_echo});
    endtask

    task automatic full_frame(input logic [7:0] b);
        int p0;
        p0 = pulses;
        begin_frame();
        frame_byte(b);
        end_frame();
        check("byte_done count", pulses - p0, 32'd1);
        check("uo_out after frame", {24'b0, uo_out}, {24'b0, b});
    endtask

    task automatic abort_frame(input logic [7:0] b, input int n);
        int p0;
        logic [7:0] echo;
        logic [7:0] exp_echo;
        exp_echo = model_prev >> (8 - n);
        p0 = pulses;
        begin_frame();
        shift_bits(b, n, echo);
        end_frame();
        check("abort echo prefix", {24'b0, echo}, {24'b0, exp_echo});
        check("abort no byte_done", pulses - p0, 32'd0);
        check("uo_out after abort", {24'b0, uo_out}, {24'b0, model_prev});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [7:0] echo;
        logic [7:0] r;
        ena   = 1'b1;
        rst_n = 1'b0;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;

        // Reset
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("reset uo_out", {24'b0, uo_out}, 32'h00);
        check("reset uio_out", {24'b0, uio_out}, 32'h00);
        check("reset uio_oe", {24'b0, uio_oe}, 32'h07);

        // Single byte, then echo
        full_frame(8'hA5);
        full_frame(8'h3C);

        // Abort after 5 bits, then a full frame
        abort_frame(8'hFF, 5);
        full_frame(8'h96);

        // MOSI toggling without SCLK
        p0 = pulses;
        cs_n = 1'b0;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            mosi = ~mosi;
            tick(1);
        end
        cs_n = 1'b1;
        tick(6);
        check("no-sclk byte_done", pulses - p0, 32'd0);
        check("no-sclk uo_out", {24'b0, uo_out}, {24'b0, model_prev});

        // Reset in the middle of a frame
        begin_frame();
        shift_bits(8'hC3, 4, echo);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        model_prev = 8'h00;
        tick(1);
        check("mid-reset uo_out", {24'b0, uo_out}, 32'h00);
        check("mid-reset busy", {31'b0, uio_out[2]}, 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Back-to-back bytes under one CS low
        p0 = pulses;
        begin_frame();
        frame_byte(8'h12);
        frame_byte(8'h34);
        end_frame();
        check("back-to-back byte_done count", pulses - p0, 32'd2);
        check("back-to-back uo_out", {24'b0, uo_out}, 32'h34);

        // Randomized frames and aborts
        for (int k = 0; k < 10; k++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                abort_frame(r, int'($urandom_range(1, 7)));
            end else begin
                full_frame(r);
            end
        end

        // Randomized back-to-back burst
        p0 = pulses;
        begin_frame();
        for (int k = 0; k < 3; k++) begin
            frame_byte(8'($urandom));
        end
        end_frame();
        check("burst byte_done count", pulses - p0, 32'd3);
        check("burst uo_out", {24'b0, uo_out}, {24'b0, model_prev});

        tick(10);
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
